imem_arbiter: RTL and testbench

- Sequences and shares the single-port, word-organised instruction memory between two requesters: the core fetch stage (read) and a program loader (write, fed by a UART/debug path).
- Sits between the fetch stage, the loader and a synchronous-read instruction memory.
- Provides fetch-priority arbitration with a loader starvation limit, plus a load-mode that locks the core out while a program is written.
- Fetch data returns one cycle after grant.

---
 rtl/imem_arbiter.sv | 126 ++++++++++++
 tb/tb_imem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Shares a single-port, synchronous-read instruction memory between the core fetch
// stage (reads) and a program loader (writes), with a loader starvation limit and a
// load mode that locks the core out.
module imem_arbiter #(
  parameter int          N        = 2048,
  parameter int          AW       = $clog2(N),
  parameter int          MAX_WAIT = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load_mode,
  input  logic          i_fetch_req,
  input  logic [31:0]   i_fetch_addr,
  output logic          o_fetch_gnt,
  output logic          o_fetch_valid,
  output logic [31:0]   o_fetch_inst,
  input  logic          i_load_req,
  input  logic [31:0]   i_load_addr,
  input  logic [31:0]   i_load_data,
  output logic          o_load_gnt,
  output logic          o_load_err,
  output logic          o_core_stall,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            rd_pend_q;   // a fetch was granted last cycle
  logic            rd_oor_q;    // ... and it was out of range
  logic [31:0]     inst_q;
  logic            load_err_q;

  logic            fetch_oor, load_oor;
  logic            load_win;
  logic            fetch_gnt, load_gnt;
  logic            fetch_valid;
  logic [31:0]     fetch_inst;

  // Byte-lane bits of word addresses carry no information here.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_fetch_addr[1:0], i_load_addr[1:0]};

  // NOTE: every signal written in an always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    fetch_oor = ({2'b00, i_fetch_addr[31:2]} >= 32'(N));
    load_oor  = ({2'b00, i_load_addr[31:2]}  >= 32'(N));
    load_win  = (wait_q == WW'(MAX_WAIT)) && i_load_req;
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (!i_reset) begin
      if (state_q == ST_LOAD) begin
        load_gnt = i_load_req;
      end else if (load_win) begin
        load_gnt = 1'b1;
      end else if (i_fetch_req) begin
        fetch_gnt = 1'b1;
      end else begin
        load_gnt = i_load_req;
      end
    end
  end

  always_comb begin
    state_d = i_load_mode ? ST_LOAD : ST_RUN;
    wait_d  = '0;
    if (state_q == ST_RUN && i_load_req && !load_gnt) begin
      wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + WW'(1);
    end
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = i_load_data;
    if (fetch_gnt) begin
      o_mem_addr = i_fetch_addr[AW+1:2];
    end else if (load_gnt) begin
      o_mem_addr = i_load_addr[AW+1:2];
      o_mem_we   = !load_oor;
    end
  end

  // A read still in flight when reset arrives never surfaces as valid data.
  assign fetch_valid = rd_pend_q && !i_reset;
  assign fetch_inst  = fetch_valid ? (rd_oor_q ? NOP_INST : i_mem_rdata) : inst_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_RUN;
      wait_q     <= '0;
      rd_pend_q  <= 1'b0;
      rd_oor_q   <= 1'b0;
      inst_q     <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rd_pend_q  <= fetch_gnt;
      rd_oor_q   <= fetch_gnt && fetch_oor;
      inst_q     <= fetch_inst;
      load_err_q <= load_gnt && load_oor;
    end
  end

  assign o_fetch_gnt   = fetch_gnt;
  assign o_load_gnt    = load_gnt;
  assign o_fetch_valid = fetch_valid;
  assign o_fetch_inst  = fetch_inst;
  assign o_load_err    = load_err_q;
  assign o_core_stall  = i_fetch_req && !fetch_gnt;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: drives inputs on the falling edge, checks
// outputs 1 ns later against hand-computed values, with a behavioural memory.
module tb_imem_arbiter;

  localparam int N  = 2048;
  localparam int AW = 11;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_load_mode;
  logic          i_fetch_req;
  logic [31:0]   i_fetch_addr;
  logic          o_fetch_gnt;
  logic          o_fetch_valid;
  logic [31:0]   o_fetch_inst;
  logic          i_load_req;
  logic [31:0]   i_load_addr;
  logic [31:0]   i_load_data;
  logic          o_load_gnt;
  logic          o_load_err;
  logic          o_core_stall;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_we;
  logic [31:0]   o_mem_wdata;
  logic [31:0]   i_mem_rdata;

  logic          mem_init;
  logic [31:0]   mem [N];

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  imem_arbiter #(.N(N), .AW(AW), .MAX_WAIT(4), .NOP_INST(32'h0000_0013)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_load_mode(i_load_mode),
    .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
    .o_fetch_gnt(o_fetch_gnt), .o_fetch_valid(o_fetch_valid), .o_fetch_inst(o_fetch_inst),
    .i_load_req(i_load_req), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
    .o_load_gnt(o_load_gnt), .o_load_err(o_load_err), .o_core_stall(o_core_stall),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  // Synchronous-read memory; word i starts out as 0xA000_0000 + i.
  always @(posedge i_clk) begin
    if (mem_init) begin
      for (int i = 0; i < N; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (o_mem_we) begin
      mem[o_mem_addr] <= o_mem_wdata;
    end
    i_mem_rdata <= mem[o_mem_addr];
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic idle();
    i_fetch_req  = 1'b0;
    i_fetch_addr = 32'h0;
    i_load_req   = 1'b0;
    i_load_addr  = 32'h0;
    i_load_data  = 32'h0;
  endtask

  task automatic test_reset();
    mem_init = 1'b1; i_reset = 1'b1; i_load_mode = 1'b0;
    i_fetch_req = 1'b1; i_fetch_addr = 32'h8;
    i_load_req = 1'b1; i_load_addr = 32'h14; i_load_data = 32'h1;
    tick(); #1;
    n_cmp++; if (o_fetch_gnt !== 1'b0) begin n_err++; $display("FAIL rst_fetch_gnt: got %b want 0", o_fetch_gnt); end
    n_cmp++; if (o_load_gnt !== 1'b0) begin n_err++; $display("FAIL rst_load_gnt: got %b want 0", o_load_gnt); end
    n_cmp++; if (o_mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b want 0", o_mem_we); end
    n_cmp++; if (o_mem_addr !== 11'd0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", o_mem_addr); end
    tick(); mem_init = 1'b0; idle();
    tick(); i_reset = 1'b0; #1;
    n_cmp++; if (o_fetch_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", o_fetch_valid); end
    n_cmp++; if (o_fetch_inst !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h want 0", o_fetch_inst); end
    n_cmp++; if (o_load_err !== 1'b0) begin n_err++; $display("FAIL rst_load_err: got %b want 0", o_load_err); end
    n_cmp++; if (o_core_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", o_core_stall); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_inst [3];
    exp_inst[0] = 32'hA000_0000; exp_inst[1] = 32'hA000_0001; exp_inst[2] = 32'hA000_0002;
    for (int k = 0; k < 3; k++) begin
      tick(); i_fetch_req = 1'b1; i_fetch_addr = 32'(4 * k); #1;
      n_cmp++; if (o_fetch_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt%0d: got %b want 1", k, o_fetch_gnt); end
      n_cmp++; if (o_mem_addr !== 11'(k)) begin n_err++; $display("FAIL b2b_addr%0d: got %h want %h", k, o_mem_addr, k); end
      n_cmp++; if (o_fetch_valid !== (k > 0)) begin n_err++; $display("FAIL b2b_valid%0d: got %b want %b", k, o_fetch_valid, k > 0); end
      if (k > 0) begin
        n_cmp++; if (o_fetch_inst !== exp_inst[k-1]) begin n_err++; $display("FAIL b2b_inst%0d: got %h want %h", k, o_fetch_inst, exp_inst[k-1]); end
      end
    end
    tick(); idle(); #1;
    n_cmp++; if (o_fetch_valid !== 1'b1 || o_fetch_inst !== exp_inst[2]) begin n_err++; $display("FAIL b2b_last: got %b/%h want 1/%h", o_fetch_valid, o_fetch_inst, exp_inst[2]); end
    tick(); #1;
    n_cmp++; if (o_fetch_valid !== 1'b0 || o_fetch_inst !== exp_inst[2]) begin n_err++; $display("FAIL b2b_hold: got %b/%h want 0/%h", o_fetch_valid, o_fetch_inst, exp_inst[2]); end
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 5; k++) begin
      tick(); i_fetch_req = 1'b1; i_fetch_addr = 32'h40;
      i_load_req = 1'b1; i_load_addr = 32'h10; i_load_data = 32'hDEAD_BEEF; #1;
      if (k < 4) begin
        n_cmp++; if (o_fetch_gnt !== 1'b1 || o_load_gnt !== 1'b0) begin n_err++; $display("FAIL starve_deny%0d: got fg=%b lg=%b want fg=1 lg=0", k, o_fetch_gnt, o_load_gnt); end
        n_cmp++; if (o_mem_we !== 1'b0 || o_mem_addr !== 11'd16) begin n_err++; $display("FAIL starve_rd%0d: got we=%b a=%h want we=0 a=010", k, o_mem_we, o_mem_addr); end
      end else begin
        n_cmp++; if (o_load_gnt !== 1'b1 || o_fetch_gnt !== 1'b0) begin n_err++; $display("FAIL starve_win: got lg=%b fg=%b want lg=1 fg=0", o_load_gnt, o_fetch_gnt); end
        n_cmp++; if (o_core_stall !== 1'b1) begin n_err++; $display("FAIL starve_stall: got %b want 1", o_core_stall); end
        n_cmp++; if (o_mem_we !== 1'b1 || o_mem_addr !== 11'd4 || o_mem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL starve_wr: got we=%b a=%h d=%h want we=1 a=004 d=deadbeef", o_mem_we, o_mem_addr, o_mem_wdata); end
      end
      if (k > 0 && k < 4) begin
        n_cmp++; if (o_fetch_valid !== 1'b1 || o_fetch_inst !== 32'hA000_0010) begin n_err++; $display("FAIL starve_inst%0d: got %b/%h want 1/a0000010", k, o_fetch_valid, o_fetch_inst); end
      end
    end
    tick(); i_load_req = 1'b0; i_fetch_addr = 32'h10; #1;
    n_cmp++; if (o_fetch_gnt !== 1'b1 || o_fetch_valid !== 1'b0) begin n_err++; $display("FAIL starve_after: got fg=%b v=%b want fg=1 v=0", o_fetch_gnt, o_fetch_valid); end
    tick(); idle(); #1;
    n_cmp++; if (o_fetch_valid !== 1'b1 || o_fetch_inst !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL starve_readback: got %b/%h want 1/deadbeef", o_fetch_valid, o_fetch_inst); end
  endtask

  task automatic test_load_mode();
    tick(); i_load_mode = 1'b1; i_fetch_req = 1'b1; i_fetch_addr = 32'h0; #1;
    n_cmp++; if (o_fetch_gnt !== 1'b1) begin n_err++; $display("FAIL lm_last_run_gnt: got %b want 1", o_fetch_gnt); end
    for (int i = 0; i < 8; i++) begin
      tick(); i_load_req = 1'b1; i_load_addr = 32'h100 + 32'(4 * i); i_load_data = 32'h5500_0000 + 32'(i); #1;
      n_cmp++; if (o_fetch_gnt !== 1'b0 || o_core_stall !== 1'b1) begin n_err++; $display("FAIL lm_block%0d: got fg=%b st=%b want fg=0 st=1", i, o_fetch_gnt, o_core_stall); end
      n_cmp++; if (o_load_gnt !== 1'b1 || o_mem_we !== 1'b1 || o_mem_addr !== 11'(64 + i)) begin n_err++; $display("FAIL lm_write%0d: got lg=%b we=%b a=%h want lg=1 we=1 a=%h", i, o_load_gnt, o_mem_we, o_mem_addr, 64 + i); end
      if (i == 0) begin
        n_cmp++; if (o_fetch_valid !== 1'b1 || o_fetch_inst !== 32'hA000_0000) begin n_err++; $display("FAIL lm_first_data: got %b/%h want 1/a0000000", o_fetch_valid, o_fetch_inst); end
      end
    end
    tick(); i_load_mode = 1'b0; i_load_req = 1'b0; #1;
    n_cmp++; if (o_fetch_gnt !== 1'b0) begin n_err++; $display("FAIL lm_exit_lag: got %b want 0", o_fetch_gnt); end
    tick(); i_fetch_addr = 32'h104; #1;
    n_cmp++; if (o_fetch_gnt !== 1'b1 || o_mem_addr !== 11'd65) begin n_err++; $display("FAIL lm_resume: got fg=%b a=%h want fg=1 a=041", o_fetch_gnt, o_mem_addr); end
    tick(); idle(); #1;
    n_cmp++; if (o_fetch_valid !== 1'b1 || o_fetch_inst !== 32'h5500_0001) begin n_err++; $display("FAIL lm_readback: got %b/%h want 1/55000001", o_fetch_valid, o_fetch_inst); end
  endtask

  task automatic test_out_of_range();
    tick(); i_fetch_req = 1'b1; i_fetch_addr = 32'h0000_2000; #1;
    n_cmp++; if (o_fetch_gnt !== 1'b1 || o_mem_we !== 1'b0) begin n_err++; $display("FAIL oor_fetch_gnt: got fg=%b we=%b want fg=1 we=0", o_fetch_gnt, o_mem_we); end
    tick(); idle(); #1;
    n_cmp++; if (o_fetch_valid !== 1'b1 || o_fetch_inst !== 32'h0000_0013) begin n_err++; $display("FAIL oor_nop: got %b/%h want 1/00000013", o_fetch_valid, o_fetch_inst); end
    tick(); i_load_req = 1'b1; i_load_addr = 32'h0000_2000; i_load_data = 32'hFFFF_FFFF; #1;
    n_cmp++; if (o_load_gnt !== 1'b1 || o_mem_we !== 1'b0 || o_load_err !== 1'b0) begin n_err++; $display("FAIL oor_wr_gnt: got lg=%b we=%b err=%b want 1/0/0", o_load_gnt, o_mem_we, o_load_err); end
    tick(); idle(); #1;
    n_cmp++; if (o_load_err !== 1'b1) begin n_err++; $display("FAIL oor_err_pulse: got %b want 1", o_load_err); end
    tick(); i_fetch_req = 1'b1; i_fetch_addr = 32'h0; #1;
    n_cmp++; if (o_load_err !== 1'b0) begin n_err++; $display("FAIL oor_err_clear: got %b want 0", o_load_err); end
    tick(); idle(); #1;
    n_cmp++; if (o_fetch_inst !== 32'hA000_0000) begin n_err++; $display("FAIL oor_mem_intact: got %h want a0000000", o_fetch_inst); end
  endtask

  task automatic test_read_after_write();
    tick(); i_fetch_req = 1'b1; i_fetch_addr = 32'h20; #1;
    n_cmp++; if (o_fetch_gnt !== 1'b1) begin n_err++; $display("FAIL raw_gnt: got %b want 1", o_fetch_gnt); end
    tick(); idle(); i_load_req = 1'b1; i_load_addr = 32'h20; i_load_data = 32'h1234_5678; #1;
    n_cmp++; if (o_load_gnt !== 1'b1 || o_mem_we !== 1'b1 || o_mem_addr !== 11'd8) begin n_err++; $display("FAIL raw_wr: got lg=%b we=%b a=%h want 1/1/008", o_load_gnt, o_mem_we, o_mem_addr); end
    n_cmp++; if (o_fetch_valid !== 1'b1 || o_fetch_inst !== 32'hA000_0008) begin n_err++; $display("FAIL raw_old: got %b/%h want 1/a0000008", o_fetch_valid, o_fetch_inst); end
    tick(); idle(); i_fetch_req = 1'b1; i_fetch_addr = 32'h20; #1;
    tick(); idle(); #1;
    n_cmp++; if (o_fetch_valid !== 1'b1 || o_fetch_inst !== 32'h1234_5678) begin n_err++; $display("FAIL raw_new: got %b/%h want 1/12345678", o_fetch_valid, o_fetch_inst); end
  endtask

  task automatic test_reset_inflight();
    // Build up the wait counter and request LOAD, then reset with a read in flight.
    tick(); i_fetch_req = 1'b1; i_fetch_addr = 32'h0;
    i_load_req = 1'b1; i_load_addr = 32'h30; i_load_data = 32'h0BAD_F00D;
    tick(); i_load_mode = 1'b1; #1;
    n_cmp++; if (o_fetch_gnt !== 1'b1) begin n_err++; $display("FAIL rif_pre_gnt: got %b want 1", o_fetch_gnt); end
    tick(); i_reset = 1'b1; #1;
    n_cmp++; if (o_fetch_valid !== 1'b0) begin n_err++; $display("FAIL rif_valid_rst: got %b want 0", o_fetch_valid); end
    n_cmp++; if (o_fetch_gnt !== 1'b0 || o_load_gnt !== 1'b0) begin n_err++; $display("FAIL rif_gnt_rst: got fg=%b lg=%b want 0/0", o_fetch_gnt, o_load_gnt); end
    for (int k = 0; k < 5; k++) begin
      tick(); i_reset = 1'b0; i_load_mode = 1'b0; #1;
      if (k == 0) begin
        n_cmp++; if (o_fetch_valid !== 1'b0) begin n_err++; $display("FAIL rif_dropped: got %b want 0", o_fetch_valid); end
      end
      n_cmp++; if (o_load_gnt !== (k == 4) || o_fetch_gnt !== (k != 4)) begin n_err++; $display("FAIL rif_wait%0d: got lg=%b fg=%b want lg=%b fg=%b", k, o_load_gnt, o_fetch_gnt, k == 4, k != 4); end
    end
    tick(); idle(); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_back_to_back();
    test_starvation();
    test_load_mode();
    test_out_of_range();
    test_read_after_write();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
